// File: rtl/dcim_feeder.sv
// Bit-plane transmitter for the 4-column DCIM accumulator: 4 MSB-first beats per activation vector.
// Optional DCIM_FEEDER_OREG_EN adds one output register stage on out_valid/d1..d4.
module dcim_feeder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         w_load,
  input  logic [1:0]   w_col,
  input  logic [127:0] w_data,
  output logic         w_ready,
  input  logic         act_valid,
  input  logic [127:0] act_data,
  output logic         act_ready,
  output logic         out_valid,
  output logic [127:0] d1,
  output logic [127:0] d2,
  output logic [127:0] d3,
  output logic [127:0] d4
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] act_q, act_d;
  logic [127:0] w_q [4];
  logic         accept_s;
  logic         w_wr_s;
  logic         valid_s;
  logic [127:0] d_s [4];

  // Lane i keeps its weight nibble only when activation bit (3-beat) of lane i is set.
  function automatic logic [127:0] mask_plane(input logic [127:0] w, input logic [127:0] a,
                                              input logic [1:0] beat);
    logic [127:0] r;
    logic [1:0]   sel;
    r   = 128'd0;
    sel = 2'd3 - beat;
    for (int i = 0; i < 32; i++) begin
      r[4*i +: 4] = w[4*i +: 4] & {4{a[4*i + int'(sel)]}};
    end
    return r;
  endfunction

  assign w_ready   = rst_n & (state_q == ST_IDLE);
  assign act_ready = rst_n & ((state_q == ST_IDLE) ? ~w_load : (beat_q == 2'd3));
  assign accept_s  = act_valid & act_ready;
  assign w_wr_s    = w_load & w_ready;

  // Next-state: beat sequencing and back-to-back reload at beat 3.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (accept_s) begin
      act_d = act_data;
    end else begin
      act_d = act_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_STREAM;
          beat_d  = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (beat_q == 2'd3) begin
          beat_d = 2'd0;
          if (accept_s) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 2'd0;
      end
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Activation buffer and weight store carry no reset; outputs are masked while idle.
  always_ff @(posedge clk) begin
    act_q <= act_d;
    if (w_wr_s) begin
      w_q[w_col] <= w_data;
    end
  end

  // Beat data forced to zero whenever no beat is being presented.
  always_comb begin
    valid_s = (state_q == ST_STREAM);
    for (int c = 0; c < 4; c++) begin
      if (valid_s) begin
        d_s[c] = mask_plane(w_q[c], act_q, beat_q);
      end else begin
        d_s[c] = 128'd0;
      end
    end
  end

`ifdef DCIM_FEEDER_OREG_EN
  logic         out_valid_q;
  logic [127:0] d_q [4];

  // Extra output stage; reset clears it so the stream aborts cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      for (int c = 0; c < 4; c++) d_q[c] <= 128'd0;
    end else begin
      out_valid_q <= valid_s;
      for (int c = 0; c < 4; c++) d_q[c] <= d_s[c];
    end
  end

  assign out_valid = out_valid_q;
  assign d1 = d_q[0];
  assign d2 = d_q[1];
  assign d3 = d_q[2];
  assign d4 = d_q[3];
`else
  assign out_valid = valid_s;
  assign d1 = d_s[0];
  assign d2 = d_s[1];
  assign d3 = d_s[2];
  assign d4 = d_s[3];
`endif

endmodule

// File: doc/dcim_feeder.md
# dcim_feeder

- Bit-plane transmitter for the 4-column DCIM accumulator: it produces the 4-beat, MSB-first `in_valid` / `in_data1..4` stream that the accumulator consumes.
- It holds a 32×4-bit weight vector per column and accepts one 32×4-bit activation vector through a valid/ready handshake.
- For each accepted vector it emits exactly 4 consecutive beats, one per activation bit-plane (bit 3 down to bit 0). Each nibble on a beat is a weight masked by one activation bit.
- Back-to-back vectors stream without gaps, matching the downstream mod-4 beat counter.

## Interface
Parameters:
- none; 32 lanes × 4 bit, 4 columns, 4 beats are fixed.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `w_load` in 1: write the weight vector of column `w_col`.
- `w_col` in 2: column select; 0..3 map to `d1..d4`.
- `w_data` in 128: weight nibbles; lane i = `[4i+3:4i]`.
- `w_ready` out 1: weight writes accepted this cycle.
- `act_valid` in 1: activation vector offered.
- `act_data` in 128: activation nibbles; lane i = `[4i+3:4i]`.
- `act_ready` out 1: activation accepted when `act_valid & act_ready`.
- `out_valid` out 1: beat valid; drives downstream `in_valid`.
- `d1`, `d2`, `d3`, `d4` out 128 each: beat data for columns 0..3; drive downstream `in_data1..4`.

## Operation
- Weight store: 4×128-bit registers, not reset (contents undefined until loaded).
  - Write on `w_load & w_ready`.
  - `w_load` while `w_ready` = 0 is dropped silently.
- Activation buffer: 128-bit register, loaded on accept.
- States:
  - IDLE: `w_ready` = 1. `act_ready` = ~`w_load`.
    - On accept, go to STREAM with beat = 0.
  - STREAM: beat counter 0..3. `w_ready` = 0. `act_ready` = (beat == 3).
    - Beat 3 with accept: beat wraps to 0 and the new vector streams on the next beat with no bubble.
    - Beat 3 without accept: go to IDLE.
- Beat data: `d<c>[4i+3:4i]` = `W[c][i]` & {4{`A[i][3-beat]`}}.
- `d1..d4` are 0 whenever `out_valid` = 0.
- `w_load` and `act_valid` asserted in the same IDLE cycle: the weight write wins and the activation waits one cycle, so the new vector uses the new weights.
- Weights cannot change mid-vector.
- Downstream contract: each column result is ≤ 32·15·15 = 7200, which fits 13 bits.

## Timing
- Reset values (any cycle with `rst_n` = 0, effective at the edge):
  - state IDLE, beat 0.
  - `out_valid` 0, `d1..d4` 0.
  - `act_ready` 0 and `w_ready` 0 while `rst_n` is low.
- Accept at edge N: beat 0 is valid in cycle N+1, beat 3 in cycle N+4 (base build).
- Continuous `act_valid`: `out_valid` stays high every cycle and `act_ready` pulses once every 4 cycles.
- Reset mid-burst: burst aborted, `out_valid` 0 from the next cycle.
  - The downstream block must share `rst_n` so its beat counter realigns.
- `act_ready` is combinational from state and `w_load`. All other outputs come from registers or masked register values; there is no combinational path from `act_data` to `d*`.

## Configuration
- `DCIM_FEEDER_OREG_EN` defined: `out_valid` and `d1..d4` pass through an extra output register stage.
  - Accept-to-first-beat latency becomes 2 cycles (beat 0 in cycle N+2).
  - Handshake timing is unchanged.
  - Reset clears the output stage to 0.
- Undefined: outputs are masked directly from the state/activation/weight registers, with 1-cycle latency as in Timing.

## Test plan
- Load col0 = 128'h1111…1, cols 1–3 = 0, activation all 0xA → beats 0..3: `d1` = 128'h1111…1, 0, 128'h1111…1, 0; `d2..d4` = 0. The downstream O1 result is 320.
- All weights 0xF, activation all 0xF → 4 beats all-ones on every column. The downstream O1..O4 results are 7200.
- `act_valid` held for two vectors → 8 consecutive `out_valid` cycles with no gap; `act_ready` is high only in IDLE and at beat 3.
- `w_load` (col 2, 128'h2222…2) with `act_valid` in the same IDLE cycle → `act_ready` is 0 that cycle, the vector is accepted next cycle, and the `d3` beats use 0x2.
- `w_load` during STREAM → `w_ready` is 0 and the next vector shows the old weights unchanged.
- `rst_n` low at beat 1 → next cycle `out_valid` = 0 and `d*` = 0; a fresh accept restarts from beat 0. Repeat with `DCIM_FEEDER_OREG_EN` and check beat 0 arrives at N+2.
